out_port_stats: RTL and testbench



---
 rtl/out_port_stats_pkg.sv | 8 +
 rtl/fallthrough_small_fifo.sv | 69 ++++++
 rtl/out_port_stats.sv | 175 +++++++++++++++++
 tb/tb_out_port_stats.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_port_stats_pkg.sv
// Shared IOQ header constants for the output-port statistics stage.
package out_port_stats_pkg;

  localparam logic [7:0]  IO_QUEUE_STAGE_NUM = 8'hFF;
  localparam int unsigned IOQ_DST_PORT_POS   = 0;
  localparam int unsigned FIFO_DEPTH_BITS    = 3;

endpackage : out_port_stats_pkg

// File: rtl/fallthrough_small_fifo.sv
// Small FIFO with a prefetched output register: the head word is visible
// on dout whenever empty is low, and rd_en consumes it.
module fallthrough_small_fifo
  import out_port_stats_pkg::*;
#(
  parameter int unsigned WIDTH          = 72,
  parameter int unsigned MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty
);

  localparam int unsigned DEPTH   = 1 << MAX_DEPTH_BITS;
  localparam int unsigned COUNT_W = MAX_DEPTH_BITS + 1;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [COUNT_W-1:0]        count;
  logic                      dout_valid;
  logic                      push_c;
  logic                      pop_c;
  logic                      load_c;

  assign full        = (count == COUNT_W'(DEPTH));
  assign nearly_full = (count >= COUNT_W'(DEPTH - 1));
  assign empty       = !dout_valid;

  assign push_c = wr_en && !full;
  assign pop_c  = rd_en && dout_valid;
  // Refill the output register whenever it is free or being consumed.
  assign load_c = (count != '0) && (!dout_valid || pop_c);

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
      if (load_c) begin
        rd_ptr     <= rd_ptr + MAX_DEPTH_BITS'(1);
        dout       <= mem[rd_ptr];
        dout_valid <= 1'b1;
      end else if (pop_c) begin
        dout_valid <= 1'b0;
      end
      case ({push_c, load_c})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : fallthrough_small_fifo

// File: rtl/out_port_stats.sv
// Buffers packets, drops those with an empty one-hot destination, forwards
// the rest bit-exact and keeps saturating per-port and drop counters.
module out_port_stats
  import out_port_stats_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_PORTS  = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic                         out_wr,
  input  logic                         out_rdy,
  input  logic [$clog2(NUM_PORTS)-1:0] stat_sel,
  input  logic                         stat_clr,
  output logic [CNT_WIDTH-1:0]         stat_pkt_cnt,
  output logic [CNT_WIDTH-1:0]         stat_drop_cnt
);

  localparam int unsigned FIFO_WIDTH = CTRL_WIDTH + DATA_WIDTH;

  typedef enum logic [2:0] {
    WAIT_HDR,
    FWD_HDR,
    FWD_BODY,
    DROP_HDR,
    DROP_BODY
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [FIFO_WIDTH-1:0]   fifo_dout;
  logic [DATA_WIDTH-1:0]   head_data;
  logic [CTRL_WIDTH-1:0]   head_ctrl;
  logic [NUM_PORTS-1:0]    dst_ports;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    fifo_nearly_full;
  logic                    fifo_reset;
  logic                    head_is_ioq;
  logic                    head_is_body;
  logic                    pop_c;
  logic                    fwd_c;
  logic                    drop_inc_c;
  logic                    pkt_inc_c;
  logic [CNT_WIDTH-1:0]    pkt_cnt [NUM_PORTS];
  logic [CNT_WIDTH-1:0]    drop_cnt;

  assign fifo_reset = !reset_n;

  fallthrough_small_fifo #(
    .WIDTH          (FIFO_WIDTH),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_in_fifo (
    .clk         (clk),
    .reset       (fifo_reset),
    .din         ({in_ctrl, in_data}),
    .wr_en       (in_wr && !fifo_full),
    .rd_en       (pop_c),
    .dout        (fifo_dout),
    .full        (fifo_full),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty)
  );

  assign in_rdy       = !fifo_nearly_full;
  assign head_ctrl    = fifo_dout[FIFO_WIDTH-1:DATA_WIDTH];
  assign head_data    = fifo_dout[DATA_WIDTH-1:0];
  assign dst_ports    = head_data[IOQ_DST_PORT_POS +: NUM_PORTS];
  assign head_is_ioq  = (head_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM));
  assign head_is_body = (head_ctrl == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_HDR;
    else          state <= state_next;
  end

  // Packet walker: header classification, then header/body/EOP tracking.
  always_comb begin
    state_next = state;
    pop_c      = 1'b0;
    fwd_c      = 1'b0;
    drop_inc_c = 1'b0;
    pkt_inc_c  = 1'b0;
    unique case (state)
      WAIT_HDR: begin
        if (!fifo_empty) begin
          if (!head_is_ioq) begin
            pop_c      = 1'b1;
            drop_inc_c = 1'b1;
          end else if (dst_ports == '0) begin
            pop_c      = 1'b1;
            drop_inc_c = 1'b1;
            state_next = DROP_HDR;
          end else if (out_rdy) begin
            pop_c      = 1'b1;
            fwd_c      = 1'b1;
            pkt_inc_c  = 1'b1;
            state_next = FWD_HDR;
          end
        end
      end
      FWD_HDR: begin
        if (out_rdy && !fifo_empty) begin
          pop_c = 1'b1;
          fwd_c = 1'b1;
          if (head_is_body) state_next = FWD_BODY;
        end
      end
      FWD_BODY: begin
        if (out_rdy && !fifo_empty) begin
          pop_c = 1'b1;
          fwd_c = 1'b1;
          if (!head_is_body) state_next = WAIT_HDR;
        end
      end
      DROP_HDR: begin
        if (!fifo_empty) begin
          pop_c = 1'b1;
          if (head_is_body) state_next = DROP_BODY;
        end
      end
      DROP_BODY: begin
        if (!fifo_empty) begin
          pop_c = 1'b1;
          if (!head_is_body) state_next = WAIT_HDR;
        end
      end
      default: state_next = WAIT_HDR;
    endcase
  end

  // Output bus holds the last forwarded word between writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= fwd_c;
      if (fwd_c) begin
        out_data <= head_data;
        out_ctrl <= head_ctrl;
      end
    end
  end

  // Saturating counters; a clear overrides any increment in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) pkt_cnt[i] <= '0;
    end else if (stat_clr) begin
      drop_cnt <= '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) pkt_cnt[i] <= '0;
    end else begin
      if (drop_inc_c && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        if (pkt_inc_c && dst_ports[i] && (pkt_cnt[i] != '1))
          pkt_cnt[i] <= pkt_cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  assign stat_pkt_cnt  = pkt_cnt[stat_sel];
  assign stat_drop_cnt = drop_cnt;

endmodule : out_port_stats

// File: tb/tb_out_port_stats.sv
// Self-checking bench: directed and random packets against a packet-level
// model; a second instance with 2-bit counters exercises saturation.
module tb_out_port_stats;

  localparam int unsigned NP = 8;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        in_rdy, s_in_rdy;
  logic [63:0] out_data, s_out_data;
  logic [7:0]  out_ctrl, s_out_ctrl;
  logic        out_wr, s_out_wr;
  logic        out_rdy = 1'b1;
  logic [2:0]  stat_sel = '0;
  logic        stat_clr = 1'b0;
  logic [31:0] stat_pkt_cnt, stat_drop_cnt;
  logic [1:0]  s_stat_pkt_cnt, s_stat_drop_cnt;

  word_t           exp_q [2][$];
  word_t           last_w [2];
  logic            prev_rdy = 1'b1;
  bit              mon_en = 1'b0;
  longint unsigned cnt_m [NP];
  longint unsigned drop_m;
  int              n_assert = 0;
  int              n_fail = 0;
  int              rdy_mode = 0;

  always #5 clk = ~clk;

  out_port_stats dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .stat_sel(stat_sel), .stat_clr(stat_clr),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_cnt(stat_drop_cnt)
  );

  out_port_stats #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(s_in_rdy),
    .out_data(s_out_data), .out_ctrl(s_out_ctrl), .out_wr(s_out_wr), .out_rdy(out_rdy),
    .stat_sel(stat_sel), .stat_clr(stat_clr),
    .stat_pkt_cnt(s_stat_pkt_cnt), .stat_drop_cnt(s_stat_drop_cnt)
  );

  function automatic logic [31:0] sat(input longint unsigned c, input int w);
    longint unsigned mx = (64'd1 << w) - 64'd1;
    return (c > mx) ? 32'(mx) : 32'(c);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // out_rdy pattern: 0 always high, 1 always low, 2 toggle, 3 random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = 1'b0;
      2:       out_rdy = !out_rdy;
      default: out_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic mon_inst(input int k, input logic wr, input logic [63:0] d, input logic [7:0] c);
    string p = (k != 0) ? "sat" : "main";
    word_t w;
    if (wr) begin
      chk({p, "_wr_without_rdy"}, 64'(prev_rdy), 64'd1);
      if (exp_q[k].size() == 0) begin
        chk({p, "_unexpected_wr"}, 64'(wr), 64'd0);
      end else begin
        w = exp_q[k].pop_front();
        chk({p, "_fwd_data"}, d, w.data);
        chk({p, "_fwd_ctrl"}, 64'(c), 64'(w.ctrl));
        last_w[k] = w;
      end
    end else begin
      chk({p, "_hold_data"}, d, last_w[k].data);
      chk({p, "_hold_ctrl"}, 64'(c), 64'(last_w[k].ctrl));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_inst(0, out_wr, out_data, out_ctrl);
      mon_inst(1, s_out_wr, s_out_data, s_out_ctrl);
      prev_rdy = out_rdy;
    end
  end

  task automatic write_word(input word_t w);
    int t = 0;
    while (!in_rdy && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) chk("in_rdy_timeout", 64'(in_rdy), 64'd1);
    in_data = w.data;
    in_ctrl = w.ctrl;
    in_wr   = 1'b1;
    @(posedge clk); #1;
    in_wr   = 1'b0;
  endtask

  // mode 0: plain; 1: latency/counter timing checks at stat_sel; 2: clear at header pop.
  task automatic send_pkt(input logic [15:0] dst, input int nbody, input int nextra, input int mode);
    word_t pkt[$];
    word_t w;
    bit fwd;
    longint unsigned pre;
    longint unsigned post;
    w.ctrl = 8'hFF;
    w.data = {$urandom, $urandom};
    w.data[15:0] = dst;
    pkt.push_back(w);
    repeat (nextra) begin
      w.ctrl = 8'($urandom_range(1, 254));
      w.data = {$urandom, $urandom};
      pkt.push_back(w);
    end
    repeat (nbody) begin
      w.ctrl = 8'h00;
      w.data = {$urandom, $urandom};
      pkt.push_back(w);
    end
    w.ctrl = 8'($urandom_range(1, 255));
    w.data = {$urandom, $urandom};
    pkt.push_back(w);
    fwd = (dst[NP-1:0] != '0);
    if (fwd) begin
      foreach (pkt[k]) begin
        exp_q[0].push_back(pkt[k]);
        exp_q[1].push_back(pkt[k]);
      end
    end
    pre  = cnt_m[stat_sel];
    post = pre + (dst[stat_sel] ? 1 : 0);
    foreach (pkt[k]) begin
      write_word(pkt[k]);
      if (mode == 2 && k == 1) stat_clr = 1'b1;
      if (mode == 2 && k == 2) stat_clr = 1'b0;
      if (mode == 1) begin
        if (k < 2) chk("latency_no_early_wr", 64'(out_wr), 64'd0);
        if (k == 1) chk("cnt_before_hdr_pop", 64'(stat_pkt_cnt), 64'(sat(pre, 32)));
        if (k == 2) begin
          chk("latency_first_wr", 64'(out_wr), 64'd1);
          chk("latency_hdr_data", out_data, pkt[0].data);
          chk("cnt_after_hdr_pop", 64'(stat_pkt_cnt), 64'(sat(post, 32)));
        end
      end
    end
    if (mode == 2) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      drop_m = 0;
    end else if (fwd) begin
      for (int i = 0; i < NP; i++) if (dst[i]) cnt_m[i]++;
    end else begin
      drop_m++;
    end
  endtask

  task automatic send_stray(input logic [7:0] c);
    word_t w;
    w.ctrl = c;
    w.data = {$urandom, $urandom};
    write_word(w);
    drop_m++;
  endtask

  task automatic drain();
    int t = 0;
    rdy_mode = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) chk("drain_timeout", 64'(exp_q[0].size()), 64'd0);
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
    for (int i = 0; i < NP; i++) begin
      stat_sel = 3'(i);
      @(negedge clk);
      chk($sformatf("%s_pkt_cnt%0d", tag, i), 64'(stat_pkt_cnt), 64'(sat(cnt_m[i], 32)));
      chk($sformatf("%s_sat_pkt_cnt%0d", tag, i), 64'(s_stat_pkt_cnt), 64'(sat(cnt_m[i], 2)));
    end
    chk({tag, "_drop_cnt"}, 64'(stat_drop_cnt), 64'(sat(drop_m, 32)));
    chk({tag, "_sat_drop_cnt"}, 64'(s_stat_drop_cnt), 64'(sat(drop_m, 2)));
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    foreach (cnt_m[i]) cnt_m[i] = 0;
    drop_m = 0;
    exp_q[0].delete();
    exp_q[1].delete();
    last_w[0] = '0;
    last_w[1] = '0;
  endtask

  initial begin
    word_t w;
    logic [15:0] dst;
    int r;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_wr", 64'(out_wr), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("reset_in_rdy", 64'(in_rdy), 64'd1);
    chk("reset_pkt_cnt", 64'(stat_pkt_cnt), 64'd0);
    chk("reset_drop_cnt", 64'(stat_drop_cnt), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Unicast forward with latency and counter-visibility checks.
    stat_sel = 3'd2;
    send_pkt(16'h0004, 2, 0, 1);
    drain();
    check_stats("fwd");

    // Empty destination dropped while back-pressured, then a forward.
    rdy_mode = 1;
    @(posedge clk); #1;
    send_pkt(16'h0000, 2, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    rdy_mode = 0;
    send_pkt(16'h0001, 2, 0, 0);
    drain();
    check_stats("drop");

    // Multicast under alternating back-pressure, with an extra module header.
    rdy_mode = 2;
    send_pkt(16'h0005, 4, 1, 0);
    drain();
    check_stats("mcast");

    // Stray non-header word in idle, then a normal packet.
    send_stray(8'h00);
    send_pkt(16'h0008, 1, 0, 0);
    drain();
    check_stats("stray");

    // Saturation on the narrow instance, then clear coinciding with a header pop.
    repeat (4) send_pkt(16'h0002, 1, 0, 0);
    drain();
    check_stats("sat");
    send_pkt(16'h0002, 1, 0, 2);
    drain();
    check_stats("clear");

    // Asynchronous reset in the middle of a forwarded packet.
    mon_en = 1'b0;
    stat_sel = 3'd3;
    for (int k = 0; k < 3; k++) begin
      w.ctrl = (k == 0) ? 8'hFF : 8'h00;
      w.data = {$urandom, $urandom};
      if (k == 0) w.data[15:0] = 16'h0008;
      write_word(w);
    end
    chk("midpkt_out_wr_before_reset", 64'(out_wr), 64'd1);
    chk("midpkt_cnt_before_reset", 64'(stat_pkt_cnt), 64'(sat(cnt_m[3] + 1, 32)));
    reset_n = 1'b0;
    #1;
    chk("midpkt_reset_out_wr", 64'(out_wr), 64'd0);
    chk("midpkt_reset_out_data", out_data, 64'd0);
    chk("midpkt_reset_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("midpkt_reset_pkt_cnt", 64'(stat_pkt_cnt), 64'd0);
    chk("midpkt_reset_sat_out_wr", 64'(s_out_wr), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    prev_rdy = out_rdy;
    mon_en = 1'b1;
    send_pkt(16'h0088, 3, 1, 0);
    drain();
    check_stats("post_reset");

    // Random traffic: strays, drops incl. high-only dst bits, multicast, random back-pressure.
    rdy_mode = 3;
    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_stray(($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(1, 254)));
      end else begin
        dst = 16'($urandom) & 16'hFF00;
        if (r != 1) dst = dst | 16'($urandom_range(1, 255));
        send_pkt(dst, $urandom_range(1, 4), $urandom_range(0, 2), 0);
      end
      rdy_mode = 3;
    end
    drain();
    check_stats("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_out_port_stats
